store_buffer: RTL and testbench

- Posted-write queue between the datapath's memory stage and the single-port, word-addressed data memory.
- Stores are accepted immediately and drained into memory one per cycle whenever the memory port is not needed by a load.
- Loads read memory through this block and are forwarded from pending stores that target the same word.
- Memory read is combinational; memory write happens on clk rising edge; one shared address port.

---
 rtl/store_buffer.sv | 92 +++++++++
 tb/tb_store_buffer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer between the memory stage and a single-port data memory.
// Stores drain one per cycle when loads leave the port free; loads forward from pending stores.
module store_buffer #(
    parameter int n      = 32,
    parameter int DEPTH  = 4,
    parameter int WSHIFT = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [n-1:0] st_addr,
    input  logic [n-1:0] st_data,
    input  logic         ld_req,
    input  logic [n-1:0] ld_addr,
    output logic [n-1:0] ld_data,
    output logic         ld_hit,
    input  logic         fence,
    output logic         busy,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    input  logic [n-1:0] mem_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [n-1:0]  r_addr [DEPTH];
    logic [n-1:0]  r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_enq;
    logic          w_drain;
    logic          w_hit;
    logic [n-1:0]  w_fwd;
    logic [PW-1:0] w_idx;

    // DEPTH is a power of two, so the top count bit alone signals "full".
    assign st_ready = !r_count[PW] && !fence;
    assign busy     = (r_count != '0);
    assign w_enq    = st_valid && st_ready;
    assign w_drain  = busy && (!ld_req || fence);

    assign mem_we    = w_drain;
    assign mem_addr  = w_drain ? r_addr[r_head] : ld_addr;
    assign mem_wdata = r_data[r_head];

    assign ld_hit  = w_hit;
    assign ld_data = w_hit ? w_fwd : mem_rdata;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        w_hit = 1'b0;
        w_fwd = '0;
        w_idx = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if ((CW'(i) < r_count) &&
                (r_addr[w_idx][n-1:WSHIFT] == ld_addr[n-1:WSHIFT])) begin
                w_hit = 1'b1;
                w_fwd = r_data[w_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail] <= st_addr;
            r_data[r_tail] <= st_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_drain) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= r_count + CW'(w_enq) - CW'(w_drain);
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vector table, reset corner cases,
// and randomized traffic against a queue-based reference model with its own memory image.
module tb_store_buffer;

    localparam int N      = 32;
    localparam int DEPTH  = 4;
    localparam int WSHIFT = 5;
    localparam int MWORDS = 64;

    typedef struct {
        logic        ready;
        logic        busy;
        logic        we;
        logic [31:0] memAddr;
        logic [31:0] wdata;
        logic        hit;
        logic [31:0] ld;
        logic        chkLd;
    } expect_t;

    typedef struct {
        logic        stValid;
        logic [31:0] stAddr;
        logic [31:0] stData;
        logic        ldReq;
        logic [31:0] ldAddr;
        logic        fence;
        expect_t     e;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    logic         clk;
    logic         rst_n;
    logic         st_valid;
    logic         st_ready;
    logic [N-1:0] st_addr;
    logic [N-1:0] st_data;
    logic         ld_req;
    logic [N-1:0] ld_addr;
    logic [N-1:0] ld_data;
    logic         ld_hit;
    logic         fence;
    logic         busy;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata;

    logic [31:0] dutMem [MWORDS];
    logic [31:0] refMem [MWORDS];
    logic        memLoaded = 1'b0;
    entry_t      pending [$];
    vec_t        table_q [$];
    int          checks = 0;
    int          errors = 0;

    store_buffer #(.n(N), .DEPTH(DEPTH), .WSHIFT(WSHIFT)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_hit(ld_hit),
        .fence(fence), .busy(busy),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input int i);
        return (i == 2) ? 32'h0000_AAAA : 32'h0000_A000 + 32'(i);
    endfunction

    function automatic int wordOf(input logic [31:0] a);
        return int'(a[WSHIFT+5:WSHIFT]);
    endfunction

    // Data memory: word-addressed, combinational read, write on the rising edge.
    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < MWORDS; i++) dutMem[i] <= initWord(i);
            memLoaded <= 1'b1;
        end else if (mem_we) begin
            dutMem[wordOf(mem_addr)] <= mem_wdata;
        end
    end
    assign mem_rdata = dutMem[wordOf(mem_addr)];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input expect_t e);
        cmp({tag, " st_ready"}, 32'(st_ready), 32'(e.ready));
        cmp({tag, " busy"}, 32'(busy), 32'(e.busy));
        cmp({tag, " mem_we"}, 32'(mem_we), 32'(e.we));
        cmp({tag, " mem_addr"}, mem_addr, e.memAddr);
        if (e.we) cmp({tag, " mem_wdata"}, mem_wdata, e.wdata);
        if (e.chkLd && !e.we) begin
            cmp({tag, " ld_hit"}, 32'(ld_hit), 32'(e.hit));
            cmp({tag, " ld_data"}, ld_data, e.ld);
        end
    endtask

    // Reference: pending stores as an ordered queue; loads see the youngest same-word store.
    function automatic expect_t modelExpect(input vec_t v);
        expect_t e;
        e.ready   = (pending.size() < DEPTH) && !v.fence;
        e.busy    = (pending.size() != 0);
        e.we      = (pending.size() > 0) && (!v.ldReq || v.fence);
        e.memAddr = e.we ? pending[0].addr : v.ldAddr;
        e.wdata   = e.we ? pending[0].data : 32'h0;
        e.hit     = 1'b0;
        e.ld      = refMem[wordOf(v.ldAddr)];
        for (int i = pending.size() - 1; i >= 0; i--) begin
            if ((pending[i].addr >> WSHIFT) == (v.ldAddr >> WSHIFT)) begin
                e.hit = 1'b1;
                e.ld  = pending[i].data;
                break;
            end
        end
        e.chkLd = !e.we;
        return e;
    endfunction

    task automatic applyStimulus(input vec_t v);
        st_valid = v.stValid;
        st_addr  = v.stAddr;
        st_data  = v.stData;
        ld_req   = v.ldReq;
        ld_addr  = v.ldAddr;
        fence    = v.fence;
    endtask

    task automatic runCycle(input vec_t v, input logic useTable, input string tag);
        expect_t m;
        entry_t  ent;
        applyStimulus(v);
        @(negedge clk);
        m = modelExpect(v);
        if (useTable) checkOutput({tag, " table"}, v.e);
        checkOutput({tag, " model"}, m);
        @(posedge clk);
        if (m.we) begin
            refMem[wordOf(pending[0].addr)] = pending[0].data;
            void'(pending.pop_front());
        end
        if (v.stValid && m.ready) begin
            ent.addr = v.stAddr;
            ent.data = v.stData;
            pending.push_back(ent);
        end
        #1;
    endtask

    task automatic addRow(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                          input logic lr, input logic [31:0] la, input logic f,
                          input logic rdy, input logic bsy, input logic we,
                          input logic [31:0] ma, input logic [31:0] wd,
                          input logic hit, input logic [31:0] ld, input logic chk);
        vec_t v;
        v.stValid = sv; v.stAddr = sa; v.stData = sd;
        v.ldReq = lr; v.ldAddr = la; v.fence = f;
        v.e.ready = rdy; v.e.busy = bsy; v.e.we = we; v.e.memAddr = ma; v.e.wdata = wd;
        v.e.hit = hit; v.e.ld = ld; v.e.chkLd = chk;
        table_q.push_back(v);
    endtask

    task automatic idleInputs();
        st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_req = 1'b0; ld_addr = '0; fence = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   guard;
        for (int i = 0; i < MWORDS; i++) refMem[i] = initWord(i);
        idleInputs();
        rst_n = 1'b1;

        // Reset asserted mid-cycle must take effect without a clock edge.
        #3 rst_n = 1'b0;
        #1;
        cmp("reset st_ready", 32'(st_ready), 32'd1);
        cmp("reset busy", 32'(busy), 32'd0);
        cmp("reset mem_we", 32'(mem_we), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        //     sv  stAddr    stData    lr  ldAddr   f  rdy bsy we memAddr   wdata     hit ld         chk
        addRow(0, 32'h0,   32'h0,    1, 32'h40, 0, 1, 0, 0, 32'h40,  32'h0,    0, 32'hAAAA, 1);
        addRow(1, 32'h40,  32'h1234, 0, 32'h0,  0, 1, 0, 0, 32'h0,   32'h0,    0, 32'hA000, 1);
        addRow(0, 32'h0,   32'h0,    0, 32'h0,  0, 1, 1, 1, 32'h40,  32'h1234, 0, 32'h0,    0);
        addRow(0, 32'h0,   32'h0,    0, 32'h0,  0, 1, 0, 0, 32'h0,   32'h0,    0, 32'hA000, 1);
        addRow(1, 32'h40,  32'h11,   1, 32'h44, 0, 1, 0, 0, 32'h44,  32'h0,    0, 32'h1234, 1);
        addRow(1, 32'h5F,  32'h22,   1, 32'h44, 0, 1, 1, 0, 32'h44,  32'h0,    1, 32'h11,   1);
        addRow(0, 32'h0,   32'h0,    1, 32'h44, 0, 1, 1, 0, 32'h44,  32'h0,    1, 32'h22,   1);
        addRow(0, 32'h0,   32'h0,    0, 32'h0,  0, 1, 1, 1, 32'h40,  32'h11,   0, 32'h0,    0);
        addRow(0, 32'h0,   32'h0,    0, 32'h0,  0, 1, 1, 1, 32'h5F,  32'h22,   0, 32'h0,    0);
        addRow(0, 32'h0,   32'h0,    1, 32'h40, 0, 1, 0, 0, 32'h40,  32'h0,    0, 32'h22,   1);
        addRow(1, 32'h100, 32'h1,    1, 32'h80, 0, 1, 0, 0, 32'h80,  32'h0,    0, 32'hA004, 1);
        addRow(1, 32'h120, 32'h2,    1, 32'h80, 0, 1, 1, 0, 32'h80,  32'h0,    0, 32'hA004, 1);
        addRow(1, 32'h140, 32'h3,    1, 32'h80, 0, 1, 1, 0, 32'h80,  32'h0,    0, 32'hA004, 1);
        addRow(1, 32'h160, 32'h4,    1, 32'h80, 0, 1, 1, 0, 32'h80,  32'h0,    0, 32'hA004, 1);
        addRow(1, 32'h180, 32'h5,    1, 32'h80, 0, 0, 1, 0, 32'h80,  32'h0,    0, 32'hA004, 1);
        addRow(1, 32'h180, 32'h5,    0, 32'h80, 0, 0, 1, 1, 32'h100, 32'h1,    0, 32'h0,    0);
        addRow(0, 32'h0,   32'h0,    1, 32'h80, 0, 1, 1, 0, 32'h80,  32'h0,    0, 32'hA004, 1);
        addRow(0, 32'h0,   32'h0,    1, 32'h80, 1, 0, 1, 1, 32'h120, 32'h2,    0, 32'h0,    0);
        addRow(0, 32'h0,   32'h0,    1, 32'h80, 1, 0, 1, 1, 32'h140, 32'h3,    0, 32'h0,    0);
        addRow(0, 32'h0,   32'h0,    1, 32'h80, 1, 0, 1, 1, 32'h160, 32'h4,    0, 32'h0,    0);
        addRow(0, 32'h0,   32'h0,    1, 32'h80, 1, 0, 0, 0, 32'h80,  32'h0,    0, 32'hA004, 1);
        addRow(1, 32'h200, 32'hB0,   1, 32'h0,  0, 1, 0, 0, 32'h0,   32'h0,    0, 32'hA000, 1);
        addRow(1, 32'h220, 32'hB1,   1, 32'h0,  0, 1, 1, 0, 32'h0,   32'h0,    0, 32'hA000, 1);
        addRow(1, 32'h240, 32'hB2,   0, 32'h0,  0, 1, 1, 1, 32'h200, 32'hB0,   0, 32'h0,    0);
        addRow(1, 32'h260, 32'hB3,   0, 32'h0,  0, 1, 1, 1, 32'h220, 32'hB1,   0, 32'h0,    0);
        addRow(1, 32'h280, 32'hB4,   0, 32'h0,  0, 1, 1, 1, 32'h240, 32'hB2,   0, 32'h0,    0);

        foreach (table_q[i]) runCycle(table_q[i], 1'b1, $sformatf("row%0d", i));

        // Two stores (0x260, 0x280) are still pending; reset must discard them.
        cmp("pre-reset busy", 32'(busy), 32'd1);
        idleInputs();
        #2 rst_n = 1'b0;
        #1;
        pending.delete();
        cmp("midrun reset st_ready", 32'(st_ready), 32'd1);
        cmp("midrun reset busy", 32'(busy), 32'd0);
        cmp("midrun reset mem_we", 32'(mem_we), 32'd0);
        repeat (2) begin
            @(negedge clk);
            cmp("in-reset mem_we", 32'(mem_we), 32'd0);
        end
        rst_n = 1'b1;
        v = table_q[0];
        v.ldReq = 1'b0;
        v.ldAddr = 32'h0;
        repeat (2) runCycle(v, 1'b0, "post-reset");
        cmp("discarded store word 0x260", dutMem[19], 32'hA013);
        cmp("discarded store word 0x280", dutMem[20], 32'hA014);

        // Randomized traffic over a few words so forwarding and same-word stores are frequent.
        for (int c = 0; c < 400; c++) begin
            v.stValid = ($urandom_range(0, 1) == 1);
            v.stAddr  = 32'(($urandom_range(0, 7) << WSHIFT) | $urandom_range(0, 31));
            v.stData  = $urandom;
            v.ldReq   = ($urandom_range(0, 1) == 1);
            v.ldAddr  = 32'(($urandom_range(0, 7) << WSHIFT) | $urandom_range(0, 31));
            v.fence   = ($urandom_range(0, 6) == 0);
            runCycle(v, 1'b0, "rand");
        end

        v.stValid = 1'b0;
        v.ldReq   = 1'b1;
        v.fence   = 1'b1;
        guard = 0;
        while (pending.size() != 0 && guard < 20) begin
            runCycle(v, 1'b0, "drain");
            guard++;
        end
        cmp("final drain completed", 32'(pending.size()), 32'd0);
        cmp("final busy", 32'(busy), 32'd0);
        for (int i = 0; i < MWORDS; i++) cmp($sformatf("memory word %0d", i), dutMem[i], refMem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
